scale_price_seq: RTL and testbench



---
 rtl/scale_pkg.sv | 19 +
 rtl/scale_price_seq_if.sv | 31 +++
 rtl/const_div_seq.sv | 67 ++++++
 rtl/scale_price_seq.sv | 117 +++++++++++
 tb/tb_scale_price_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/scale_pkg.sv
// Shared constants, state encoding and width helper for the scale price engine.
package scale_pkg;

    localparam int unsigned DIV_CONST  = 1000;
    localparam int unsigned ROUND_BIAS = 500;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } scale_state_t;

    // Quotient width after dividing a w_prod-bit value by 1000 (1000 > 2^9).
    function automatic int unsigned total_width(input int unsigned w_prod);
        return w_prod - 9;
    endfunction

endpackage

// File: rtl/scale_price_seq_if.sv
// Request/result bundle between weight acquisition and the price engine.
interface scale_price_seq_if
    import scale_pkg::*;
#(
    parameter int unsigned W_WEIGHT = 14,
    parameter int unsigned W_PRICE  = 14
);
    localparam int unsigned W_PROD  = W_WEIGHT + W_PRICE;
    localparam int unsigned W_TOTAL = total_width(W_PROD);

    logic                start;
    logic [W_WEIGHT-1:0] weight_g;
    logic [W_WEIGHT-1:0] tare_g;
    logic [W_PRICE-1:0]  price_cpk;
    logic                busy;
    logic                done;
    logic [W_PROD-1:0]   product;
    logic [W_TOTAL-1:0]  total_cents;
    logic                tare_err;

    modport master (
        output start, weight_g, tare_g, price_cpk,
        input  busy, done, product, total_cents, tare_err
    );

    modport slave (
        input  start, weight_g, tare_g, price_cpk,
        output busy, done, product, total_cents, tare_err
    );

endinterface

// File: rtl/const_div_seq.sv
// Restoring divider by DIV_CONST, one quotient bit per cycle, MSB first.
module const_div_seq
    import scale_pkg::*;
#(
    parameter int unsigned W_IN = 29
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic [W_IN-1:0]                    dividend,
    output logic [total_width(W_IN-1)-1:0]     quotient,
    output logic                               done
);
    localparam int unsigned W_Q  = W_IN - 1;
    localparam int unsigned W_R  = $clog2(DIV_CONST) + 1;
    localparam int unsigned W_C  = $clog2(W_Q + 1);
    localparam logic [W_R-1:0] DIVISOR = W_R'(DIV_CONST);
    localparam logic [W_C-1:0] LAST    = W_C'(W_Q - 1);

    logic [W_R-1:0] rem;
    logic [W_Q-1:0] dvd;
    logic [W_C-1:0] cnt;
    logic           active;

    logic [W_R-1:0] trial;
    logic           fits;
    logic [W_R-1:0] rem_next;

    always_comb begin
        trial    = {rem[W_R-2:0], dvd[W_Q-1]};
        fits     = (trial >= DIVISOR);
        rem_next = fits ? (trial - DIVISOR) : trial;
    end

    // The dividend MSB seeds the remainder (it is below 1000), so only
    // W_IN-1 iterations are needed; quotient bits above the register width
    // are always zero and simply shift out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem      <= W_R'(dividend[W_IN-1]);
                dvd      <= dividend[W_Q-1:0];
                cnt      <= '0;
                active   <= 1'b1;
                quotient <= '0;
            end else if (active) begin
                rem      <= rem_next;
                dvd      <= {dvd[W_Q-2:0], 1'b0};
                quotient <= {quotient[$bits(quotient)-2:0], fits};
                cnt      <= cnt + 1'b1;
                if (cnt == LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scale_price_seq.sv
// Sequential price engine: net weight, shift-add multiply by price, divide by 1000.
module scale_price_seq
    import scale_pkg::*;
#(
    parameter int unsigned W_WEIGHT = 14,
    parameter int unsigned W_PRICE  = 14,
    parameter bit          ROUND    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    scale_price_seq_if.slave  sp
);
    localparam int unsigned W_PROD  = W_WEIGHT + W_PRICE;
    localparam int unsigned W_TOTAL = total_width(W_PROD);
    localparam int unsigned W_MC    = $clog2(W_WEIGHT + 1);
    localparam logic [W_MC-1:0]   MUL_LAST = W_MC'(W_WEIGHT - 1);
    localparam logic [W_PROD:0]   BIAS     = (W_PROD + 1)'(ROUND ? ROUND_BIAS : 0);

    scale_state_t state, state_next;

    logic [W_WEIGHT-1:0] mcand;
    logic [W_PROD-1:0]   mplier;
    logic [W_PROD-1:0]   acc;
    logic [W_MC-1:0]     mul_cnt;
    logic                terr_pend;

    logic                tare_bad;
    logic [W_WEIGHT-1:0] net;
    logic [W_PROD-1:0]   acc_next;
    logic                accept;
    logic                div_load;
    logic [W_PROD:0]     dividend;
    logic [W_TOTAL-1:0]  quotient;
    logic                div_done;

    always_comb begin
        tare_bad = (sp.tare_g > sp.weight_g);
        net      = tare_bad ? '0 : (sp.weight_g - sp.tare_g);
        acc_next = acc + (mcand[0] ? mplier : '0);
        div_load = (state == MUL) && (mul_cnt == MUL_LAST);
        dividend = {1'b0, acc_next} + BIAS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (sp.start) begin
                    accept     = 1'b1;
                    state_next = MUL;
                end
            end
            MUL:     if (mul_cnt == MUL_LAST) state_next = DIV;
            DIV:     if (div_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The divider is loaded on the last multiply cycle from acc_next so DIV
    // starts on the very next edge without an extra handoff cycle.
    const_div_seq #(
        .W_IN (W_PROD + 1)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (dividend),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            mul_cnt        <= '0;
            terr_pend      <= 1'b0;
            sp.busy        <= 1'b0;
            sp.done        <= 1'b0;
            sp.product     <= '0;
            sp.total_cents <= '0;
            sp.tare_err    <= 1'b0;
        end else begin
            sp.done <= 1'b0;
            if (accept) begin
                mcand     <= net;
                mplier    <= W_PROD'(sp.price_cpk);
                acc       <= '0;
                mul_cnt   <= '0;
                terr_pend <= tare_bad;
                sp.busy   <= 1'b1;
            end
            if (state == MUL) begin
                acc     <= acc_next;
                mcand   <= mcand >> 1;
                mplier  <= mplier << 1;
                mul_cnt <= mul_cnt + 1'b1;
            end
            if ((state == DIV) && div_done) begin
                sp.product     <= acc;
                sp.total_cents <= quotient;
                sp.tare_err    <= terr_pend;
                sp.done        <= 1'b1;
            end
            if (state == DONE) sp.busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scale_price_seq.sv
// Scoreboard bench: rounding and truncating engines driven side by side.
module tb_scale_price_seq;
    import scale_pkg::*;

    localparam int unsigned WW  = 14;
    localparam int unsigned WP  = 14;
    localparam int unsigned LAT = WW + (WW + WP) + 1;

    typedef struct {
        longint unsigned prod;
        longint unsigned tot;
        bit              terr;
        longint unsigned t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t qr[$];
    exp_t qt[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scale_price_seq_if #(.W_WEIGHT(WW), .W_PRICE(WP)) ifr ();
    scale_price_seq_if #(.W_WEIGHT(WW), .W_PRICE(WP)) ift ();

    scale_price_seq #(.W_WEIGHT(WW), .W_PRICE(WP), .ROUND(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .sp(ifr)
    );
    scale_price_seq #(.W_WEIGHT(WW), .W_PRICE(WP), .ROUND(1'b0)) dut_t (
        .clk(clk), .rst_n(rst_n), .sp(ift)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic score(input string s, input exp_t e, input logic [63:0] pr,
                         input logic [63:0] tot, input logic te, input logic by);
        check({"product_", s}, pr, e.prod);
        check({"total_", s}, tot, e.tot);
        check({"tare_err_", s}, 64'(te), 64'(e.terr));
        check({"latency_", s}, cyc - e.t0 - 1, 64'(LAT));
        check({"busy_at_done_", s}, 64'(by), 64'd1);
    endtask

    always @(negedge clk) begin
        if (ifr.done) begin
            if (qr.size() == 0) check("spurious_done_r", 64'(ifr.done), 64'd0);
            else score("r", qr.pop_front(), 64'(ifr.product), 64'(ifr.total_cents),
                       ifr.tare_err, ifr.busy);
        end
        if (ift.done) begin
            if (qt.size() == 0) check("spurious_done_t", 64'(ift.done), 64'd0);
            else score("t", qt.pop_front(), 64'(ift.product), 64'(ift.total_cents),
                       ift.tare_err, ift.busy);
        end
    end

    task automatic set_in(input logic s, input int unsigned w, input int unsigned t,
                          input int unsigned p);
        ifr.start = s; ifr.weight_g = 14'(w); ifr.tare_g = 14'(t); ifr.price_cpk = 14'(p);
        ift.start = s; ift.weight_g = 14'(w); ift.tare_g = 14'(t); ift.price_cpk = 14'(p);
    endtask

    task automatic req(input int unsigned w, input int unsigned t, input int unsigned p);
        exp_t e;
        longint unsigned net;
        @(negedge clk);
        set_in(1'b1, w, t, p);
        net    = (t > w) ? 0 : longint'(w - t);
        e.prod = net * p;
        e.terr = (t > w);
        e.t0   = cyc;
        e.tot  = (e.prod + 500) / 1000;
        qr.push_back(e);
        e.tot  = e.prod / 1000;
        qt.push_back(e);
        @(negedge clk);
        set_in(1'b0, $urandom, $urandom, $urandom);
        check("busy_after_start_r", 64'(ifr.busy), 64'd1);
        check("busy_after_start_t", 64'(ift.busy), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (qr.size() != 0 || qt.size() != 0); i++) @(negedge clk);
        check("drain_r", 64'(qr.size()), 64'd0);
        check("drain_t", 64'(qt.size()), 64'd0);
        @(negedge clk);
        check("idle_busy_r", 64'(ifr.busy), 64'd0);
    endtask

    task automatic outputs_clear(input string s);
        check({"clr_busy_", s}, 64'(ifr.busy | ift.busy), 64'd0);
        check({"clr_done_", s}, 64'(ifr.done | ift.done), 64'd0);
        check({"clr_product_", s}, 64'(ifr.product | ift.product), 64'd0);
        check({"clr_total_", s}, 64'(ifr.total_cents | ift.total_cents), 64'd0);
        check({"clr_tare_err_", s}, 64'(ifr.tare_err | ift.tare_err), 64'd0);
    endtask

    initial begin
        set_in(1'b0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outputs_clear("reset");
        rst_n = 1'b1;

        req(1500, 0, 470);     drain();
        req(1500, 200, 470);   drain();
        req(1500, 0, 333);     drain();
        req(16383, 0, 16383);  drain();
        req(100, 200, 470);    drain();
        req(50, 0, 0);         drain();
        req(0, 0, 16383);      drain();

        // start mid-run must be dropped
        req(1500, 0, 470);
        repeat (8) @(negedge clk);
        set_in(1'b1, 9999, 0, 9999);
        @(negedge clk);
        set_in(1'b0, 0, 0, 0);
        drain();
        repeat (50) @(negedge clk);

        // start coinciding with the done pulse must be dropped
        req(1200, 100, 250);
        for (int i = 0; i < 100 && !ifr.done; i++) @(negedge clk);
        check("done_seen", 64'(ifr.done), 64'd1);
        set_in(1'b1, 3000, 0, 1000);
        @(negedge clk);
        set_in(1'b0, 0, 0, 0);
        check("start_in_done_busy", 64'(ifr.busy | ift.busy), 64'd0);
        repeat (50) @(negedge clk);
        check("start_in_done_q", 64'(qr.size() + qt.size()), 64'd0);

        // reset mid-operation
        req(1500, 0, 470);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        outputs_clear("abort");
        qr.delete();
        qt.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_idle", 64'(ifr.busy | ift.busy), 64'd0);
        req(1500, 200, 470);   drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
